// File: rtl/logic_ex_stage.sv
// logic_ex_stage: two-register execute stage for the logical-op path.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             synchronous kill of every in-flight op
//   in_valid/in_ready upstream handshake (in_ready depends only on stage
//                     state and out_ready, never on in_valid)
//   in_a, in_b        operands
//   in_func           000 AND, 001 OR, 010 XOR, 011 NOR, 100 NOT(A),
//                     101..111 illegal (result 0)
//   in_rd             destination register tag
//   out_valid/ready   downstream handshake
//   out_result        registered result
//   out_zero          out_result == 0
//   out_illegal       captured func was 101/110/111
//   out_rd            destination tag of the result
//
// S1 captures the operands and S2 captures the result. All out_* come
// straight from the S2 registers, so there is no combinational path from
// the operands to the outputs.

// logic_unit32: combinational 32-bit logic core.
//   a, b    operands
//   func    operation select (encoding as above)
//   result  a op b; zero for illegal codes
module logic_unit32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  func,
    output logic [31:0] result
);
    always_comb begin
        result = '0;
        case (func)
            3'b000:  result = a & b;
            3'b001:  result = a | b;
            3'b010:  result = a ^ b;
            3'b011:  result = ~(a | b);
            3'b100:  result = ~a;
            default: result = '0;
        endcase
    end
endmodule

module logic_ex_stage #(
    parameter int WIDTH = 32,   // only 32 is supported (logic_unit32 is fixed)
    parameter int TAGW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_func,
    input  logic [TAGW-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [TAGW-1:0]  out_rd
);
    // S1: operand capture
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_func;
    logic [TAGW-1:0]  s1_rd;

    // S2: result capture
    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_zero;
    logic             s2_illegal;
    logic [TAGW-1:0]  s2_rd;

    logic [31:0]      lu_result;
    logic             s2_free;
    logic             s1_move;
    logic             accept;

    logic_unit32 u_lu (
        .a      (s1_a),
        .b      (s1_b),
        .func   (s1_func),
        .result (lu_result)
    );

    always_comb begin
        s2_free  = !s2_valid || out_ready;
        s1_move  = s1_valid && s2_free;
        in_ready = !s1_valid || s2_free;
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_func    <= '0;
            s1_rd      <= '0;
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_zero    <= 1'b0;
            s2_illegal <= 1'b0;
            s2_rd      <= '0;
        end else if (flush) begin
            // Kill in-flight ops; a simultaneous in_valid is dropped even
            // though in_ready may read high this cycle.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= in_a;
                s1_b     <= in_b;
                s1_func  <= in_func;
                s1_rd    <= in_rd;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end

            if (s1_move) begin
                s2_valid   <= 1'b1;
                s2_result  <= lu_result;
                s2_zero    <= (lu_result == '0);
                s2_illegal <= (s1_func > 3'b100);
                s2_rd      <= s1_rd;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_result  = s2_result;
    assign out_zero    = s2_zero;
    assign out_illegal = s2_illegal;
    assign out_rd      = s2_rd;
endmodule

// File: tb/tb_logic_ex_stage.sv
// tb_logic_ex_stage: directed scenarios plus randomized traffic for
// logic_ex_stage, checked against a queue-based model of in-flight ops.
module tb_logic_ex_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [2:0]  in_func;
    logic [4:0]  in_rd, out_rd;
    logic        out_zero, out_illegal;

    int nchecks = 0;
    int nerrors = 0;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
        logic [4:0]  rd;
        int unsigned age;   // edges since acceptance
    } ent_t;

    ent_t q[$];   // in-flight ops, oldest first

    logic_ex_stage #(.WIDTH(32), .TAGW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_func(in_func), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero),
        .out_illegal(out_illegal), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f);
        case (f)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a | b);
            3'd4: return ~a;
            default: return 32'h0;
        endcase
    endfunction

    // Advance one rising edge and update the model: capacity 2, an op becomes
    // visible one edge after acceptance, and leaves when shown with out_ready.
    task automatic tick();
        bit   acc, pop;
        ent_t e;
        acc   = in_valid && ((q.size() < 2) || out_ready);
        pop   = (q.size() > 0) && (q[0].age >= 1) && out_ready;
        e.res = ref_op(in_a, in_b, in_func);
        e.z   = (e.res == 32'h0);
        e.ill = (in_func > 3'd4);
        e.rd  = in_rd;
        e.age = 0;
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic [4:0] rd);
        in_valid = v; in_a = a; in_b = b; in_func = f; in_rd = rd;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; out_ready = 0;
        drive(0, 0, 0, 0, 0);
        tick(); tick();
        rst = 0;
        nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        nchecks++; if (out_result !== 32'h0) begin nerrors++; $display("FAIL reset_result: got %h expected 0", out_result); end
        nchecks++; if (out_zero !== 1'b0 || out_illegal !== 1'b0) begin nerrors++; $display("FAIL reset_flags: got z=%b i=%b expected 0 0", out_zero, out_illegal); end
        nchecks++; if (out_rd !== 5'd0) begin nerrors++; $display("FAIL reset_rd: got %0d expected 0", out_rd); end
        nchecks++; if (in_ready !== 1'b1) begin nerrors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1;
        drive(1, 32'hF0F0_0000, 32'h0FF0_FFFF, 3'd0, 5'd7);
        tick();
        drive(0, 0, 0, 0, 0);
        nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL single_early: got valid=%b expected 0", out_valid); end
        tick();
        nchecks++; if (out_valid !== 1'b1) begin nerrors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        nchecks++; if (out_result !== 32'h00F0_0000) begin nerrors++; $display("FAIL single_result: got %h expected 00f00000", out_result); end
        nchecks++; if (out_zero !== 1'b0 || out_illegal !== 1'b0 || out_rd !== 5'd7) begin nerrors++; $display("FAIL single_side: got z=%b i=%b rd=%0d expected 0 0 7", out_zero, out_illegal, out_rd); end
        tick();
        nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL single_once: got valid=%b expected 0", out_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_r[4];
        logic [2:0]  fn[4];
        exp_r = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h5555_5555};
        fn    = '{3'd1, 3'd2, 3'd3, 3'd4};
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1, 32'hAAAA_AAAA, 32'h5555_5555, fn[i], 5'(i + 1));
            else       drive(0, 0, 0, 0, 0);
            tick();
            if (i >= 1) begin
                nchecks++;
                if (out_valid !== 1'b1 || out_result !== exp_r[i-1] || out_zero !== (exp_r[i-1] == 32'h0) || out_rd !== 5'(i)) begin
                    nerrors++;
                    $display("FAIL stream_%0d: got v=%b r=%h z=%b rd=%0d expected 1 %h %b %0d",
                             i - 1, out_valid, out_result, out_zero, out_rd, exp_r[i-1], exp_r[i-1] == 32'h0, i);
                end
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        a = 32'h1234_5678; b = 32'h0F0F_0F0F;
        out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            drive(1, a, b, 3'(i), 5'(10 + i));
            nchecks++; if (in_ready !== 1'b1) begin nerrors++; $display("FAIL bp_accept_%0d: got in_ready=%b expected 1", i, in_ready); end
            tick();
        end
        drive(1, a, b, 3'd2, 5'd12);
        for (int i = 0; i < 3; i++) begin
            nchecks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== (a & b) || out_rd !== 5'd10) begin
                nerrors++;
                $display("FAIL bp_hold_%0d: got rdy=%b v=%b r=%h rd=%0d expected 0 1 %h 10",
                         i, in_ready, out_valid, out_result, out_rd, a & b);
            end
            tick();
        end
        out_ready = 1;
        #1;
        nchecks++; if (in_ready !== 1'b1) begin nerrors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        tick();
        drive(0, 0, 0, 0, 0);
        nchecks++; if (out_valid !== 1'b1 || out_result !== (a | b) || out_rd !== 5'd11) begin nerrors++; $display("FAIL bp_drain_1: got v=%b r=%h rd=%0d expected 1 %h 11", out_valid, out_result, out_rd, a | b); end
        tick();
        nchecks++; if (out_valid !== 1'b1 || out_result !== (a ^ b) || out_rd !== 5'd12) begin nerrors++; $display("FAIL bp_drain_2: got v=%b r=%h rd=%0d expected 1 %h 12", out_valid, out_result, out_rd, a ^ b); end
        tick();
        nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL bp_no_extra: got valid=%b expected 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1;
        drive(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b110, 5'd3);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        nchecks++;
        if (out_valid !== 1'b1 || out_result !== 32'h0 || out_zero !== 1'b1 || out_illegal !== 1'b1 || out_rd !== 5'd3) begin
            nerrors++;
            $display("FAIL illegal: got v=%b r=%h z=%b i=%b rd=%0d expected 1 0 1 1 3",
                     out_valid, out_result, out_zero, out_illegal, out_rd);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 0;
        drive(1, 32'h1, 32'h3, 3'd1, 5'd20); tick();
        drive(1, 32'h2, 32'h3, 3'd1, 5'd21); tick();
        drive(1, 32'h4, 32'h3, 3'd1, 5'd22);
        flush = 1;
        tick();
        flush = 0; out_ready = 1;
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL flush_gone_%0d: got valid=%b rd=%0d expected 0", i, out_valid, out_rd); end
            tick();
        end
        drive(1, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'd2, 5'd9); tick();
        drive(0, 0, 0, 0, 0); tick();
        nchecks++; if (out_valid !== 1'b1 || out_result !== 32'hF0F0_F0F0 || out_rd !== 5'd9) begin nerrors++; $display("FAIL flush_after: got v=%b r=%h rd=%0d expected 1 f0f0f0f0 9", out_valid, out_result, out_rd); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 0;
        drive(1, 32'h5, 32'h6, 3'd0, 5'd1); tick();
        drive(1, 32'h7, 32'h6, 3'd1, 5'd2); tick();
        rst = 1;
        drive(1, 32'h9, 32'h6, 3'd2, 5'd3);
        tick();
        rst = 0; out_ready = 1;
        drive(0, 0, 0, 0, 0);
        nchecks++; if (out_valid !== 1'b0 || out_result !== 32'h0 || in_ready !== 1'b1) begin nerrors++; $display("FAIL rst_mid: got v=%b r=%h rdy=%b expected 0 0 1", out_valid, out_result, in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL rst_mid_stale_%0d: got valid=%b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_random();
        bit   exp_v;
        bit   exp_rdy;
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, $urandom,
                  3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 7) == 0) in_a = in_b;   // exercise XOR/AND edge cases
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            #1;
            exp_rdy = (q.size() < 2) || out_ready;
            nchecks++; if (in_ready !== exp_rdy) begin nerrors++; $display("FAIL rand_in_ready@%0d: got %b expected %b", n, in_ready, exp_rdy); end
            tick();
            exp_v = (q.size() > 0) && (q[0].age >= 1);
            nchecks++;
            if (out_valid !== exp_v) begin
                nerrors++;
                $display("FAIL rand_valid@%0d: got %b expected %b", n, out_valid, exp_v);
            end else if (exp_v) begin
                if (out_result !== q[0].res || out_zero !== q[0].z || out_illegal !== q[0].ill || out_rd !== q[0].rd) begin
                    nerrors++;
                    $display("FAIL rand_data@%0d: got r=%h z=%b i=%b rd=%0d expected %h %b %b %0d",
                             n, out_result, out_zero, out_illegal, out_rd, q[0].res, q[0].z, q[0].ill, q[0].rd);
                end
            end
        end
        flush = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_illegal();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule

// File: doc/logic_ex_stage.md
Name: logic_ex_stage

Overview:
- Pipelined execute stage for the logical-op path of the MIPS datapath.
- Sits between decode/issue and writeback/forwarding.
- Accepts operands, a 3-bit logic func code and a destination register tag over a valid/ready handshake, and instantiates logic_unit32 as its combinational core.
- Has two register stages (operand capture, result capture) with back-pressure, a zero flag, an illegal-func flag and a synchronous flush.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported, because logic_unit32 is fixed at 32 bits.
- TAGW, 5, destination register tag width.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous kill of all in-flight ops
- in_valid  input  1  upstream op valid
- in_ready  output  1  stage can accept an op this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_func  input  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 NOT(A)
- in_rd  input  TAGW  destination tag
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_result  output  WIDTH  registered result
- out_zero  output  1  out_result == 0
- out_illegal  output  1  captured func was 101/110/111
- out_rd  output  TAGW  destination tag of the result

Behaviour:
- Stages:
  - S1 holds {a, b, func, rd} plus s1_valid.
  - S2 holds {result, zero, illegal, rd} plus s2_valid.
  - out_* are driven directly from the S2 registers.
- Handshake and stage advance:
  - s2_free = !s2_valid || out_ready.
  - s1_move = s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is combinational from out_ready; there is no path from in_valid to in_ready.
  - Accept = in_valid && in_ready. On accept, S1 loads the inputs and sets s1_valid = 1.
  - If there is no accept but s1_move occurs, s1_valid clears.
- S2 load:
  - On s1_move, S2 loads result = logic_unit32(S1.a, S1.b, S1.func), zero = (result == 0), illegal = (S1.func > 3'b100), rd = S1.rd.
  - s2_valid then becomes 1.
  - If there is no s1_move and out_ready && s2_valid, s2_valid clears.
- Data in stalled stages:
  - Data registers of a stalled stage hold their value.
  - Data registers of an empty stage may hold stale values; out_result is meaningful only when out_valid = 1.
- Illegal func:
  - result = 0, so zero = 1 and illegal = 1.
  - The op still flows and is not dropped.
- Latency and throughput:
  - An op accepted at rising edge k is presented with out_valid = 1 after edge k+1 (visible in the cycle following edge k+1). That is one cycle in S1, then S2.
  - Throughput is 1 op/cycle while out_ready = 1.
- Back-pressure:
  - With out_ready = 0, S2 holds, then S1 fills, then in_ready drops to 0. At most 2 ops are buffered.
  - When out_ready returns to 1, both drain in order with no loss or duplication.
  - out_* must be stable while out_valid && !out_ready.
- Reset (rst = 1 at an edge):
  - s1_valid = s2_valid = 0.
  - out_result = 0, out_zero = 0, out_illegal = 0, out_rd = 0.
  - in_ready = 1 in the cycle after reset.
  - Reset mid-operation discards all in-flight ops.
- Flush (rst = 0, flush = 1 at an edge):
  - s1_valid and s2_valid clear; data registers need not clear.
  - A simultaneous in_valid is not captured, even though in_ready is high.
  - rst has priority over flush.
- Simultaneous events:
  - S1 can accept a new op in the same edge it moves its old op to S2.
  - S2 can load from S1 in the same edge it hands its result downstream.
- No combinational path from in_a/in_b/in_func to out_*.

Test Plan:
- Reset then single op: a=0xF0F0_0000, b=0x0FF0_FFFF, func=000, rd=7 -> after two edges, out_valid=1, out_result=0x00F0_0000, zero=0, illegal=0, out_rd=7.
- Streaming, out_ready=1: send back-to-back OR, XOR, NOR, NOT with a=0xAAAA_AAAA, b=0x5555_5555 -> results in order 0xFFFF_FFFF, 0xFFFF_FFFF, 0x0000_0000 (zero=1), 0x5555_5555, one per cycle.
- Back-pressure: hold out_ready=0 while streaming 3 ops -> in_ready falls after 2 accepts and out_* stay stable; release out_ready -> exactly 3 results in order.
- Illegal func=110, a=b=0xFFFF_FFFF -> out_result=0, zero=1, illegal=1, op delivered.
- Flush with 2 ops buffered and a new in_valid in the same cycle -> next cycle out_valid=0 and no result ever appears for any of the 3 ops; the next op after flush completes normally.
- Assert rst mid-stream with S1 and S2 full -> out_valid=0, out_result=0, in_ready=1 the following cycle; no stale op emerges.
